// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: frame FSM states,
// parity-type encodings and a 2-of-3 vote helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Front end of the UART receiver: synchronises the serial line, finds falling
// edges, times each bit with a prescale counter and votes the mid-bit samples.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  input  logic cnt_clr,
  output logic start_edge,
  output logic bit_done,
  output logic smp_valid,
  output logic smp_bit
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] CNT_S2   = CW'(PRESCALE / 2 + 1);

  logic          sync1_q;
  logic          rxS_q;
  logic          rxP_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          smp0_q, smp0_d;
  logic          smp1_q, smp1_d;

  always_comb begin
    cnt_d  = cnt_q;
    smp0_d = smp0_q;
    smp1_d = smp1_q;
    if (cnt_clr || cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    if (cnt_q == CNT_S0) smp0_d = rxS_q;
    if (cnt_q == CNT_S1) smp1_d = rxS_q;
  end

  // Synchroniser flops reset to the idle-high line level so reset cannot fake an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      rxS_q   <= 1'b1;
      rxP_q   <= 1'b1;
      cnt_q   <= '0;
      smp0_q  <= 1'b0;
      smp1_q  <= 1'b0;
    end else begin
      sync1_q <= rx_in;
      rxS_q   <= sync1_q;
      rxP_q   <= rxS_q;
      cnt_q   <= cnt_d;
      smp0_q  <= smp0_d;
      smp1_q  <= smp1_d;
    end
  end

  assign start_edge = rxP_q & ~rxS_q;
  assign bit_done   = (cnt_q == CNT_LAST);
  assign smp_valid  = (cnt_q == CNT_S2);
  assign smp_bit    = majority3(smp0_q, smp1_q, rxS_q);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, bit counter, shift register and the
// valid/ready output slot with sticky overrun detection.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int PRESCALE = 8,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  input  logic              par_en,
  input  logic              par_typ,
  input  logic              data_ready,
  output logic [DATA_W-1:0] p_data,
  output logic              data_valid,
  output logic              par_error,
  output logic              stop_error,
  output logic              overrun,
  output logic              busy
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  uart_state_e       state_q, state_d;
  logic [BW-1:0]     bitCnt_q, bitCnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parBit_q, parBit_d;
  logic              parEn_q, parEn_d;
  logic              parTyp_q, parTyp_d;
  logic [DATA_W-1:0] pData_q, pData_d;
  logic              valid_q, valid_d;
  logic              parErr_q, parErr_d;
  logic              stopErr_q, stopErr_d;
  logic              overrun_q, overrun_d;
  logic              busy_q;

  logic frameDone;
  logic frameParErr;
  logic cntClr;
  logic startEdge;
  logic bitDone;
  logic smpValid;
  logic smpBit;

  uart_rx_sampler #(
    .PRESCALE(PRESCALE)
  ) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .cnt_clr   (cntClr),
    .start_edge(startEdge),
    .bit_done  (bitDone),
    .smp_valid (smpValid),
    .smp_bit   (smpBit)
  );

  // Hold the bit timer at zero in IDLE and on every return to IDLE.
  assign cntClr = (state_q == IDLE) || (state_d == IDLE);

  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    parBit_d  = parBit_q;
    parEn_d   = parEn_q;
    parTyp_d  = parTyp_q;
    frameDone = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (startEdge) begin
          state_d  = START;
          parEn_d  = par_en;
          parTyp_d = par_typ;
        end
      end
      START: begin
        if (smpValid && smpBit) begin
          state_d = IDLE;
        end else if (bitDone) begin
          state_d  = DATA;
          bitCnt_d = '0;
        end
      end
      DATA: begin
        if (smpValid) shift_d = {smpBit, shift_q[DATA_W-1:1]};
        if (bitDone) begin
          if (bitCnt_q == BIT_LAST) begin
            state_d = parEn_q ? PARITY : STOP;
          end else begin
            bitCnt_d = bitCnt_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (smpValid) parBit_d = smpBit;
        if (bitDone) state_d = STOP;
      end
      STOP: begin
        // Leave mid-stop-bit so a back-to-back start edge is not missed.
        if (smpValid) begin
          frameDone = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign frameParErr = parEn_q & ((^{shift_q, parBit_q}) != parTyp_q);

  // A completed frame only replaces the held one if the host frees the slot this cycle.
  always_comb begin
    pData_d   = pData_q;
    valid_d   = valid_q;
    parErr_d  = parErr_q;
    stopErr_d = stopErr_q;
    overrun_d = overrun_q;
    if (frameDone && (!valid_q || data_ready)) begin
      pData_d   = shift_q;
      parErr_d  = frameParErr;
      stopErr_d = ~smpBit;
      valid_d   = 1'b1;
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
    if (valid_q && data_ready) begin
      overrun_d = 1'b0;
    end else if (frameDone && valid_q) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      parBit_q  <= 1'b0;
      parEn_q   <= 1'b0;
      parTyp_q  <= PAR_EVEN;
      pData_q   <= '0;
      valid_q   <= 1'b0;
      parErr_q  <= 1'b0;
      stopErr_q <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      parBit_q  <= parBit_d;
      parEn_q   <= parEn_d;
      parTyp_q  <= parTyp_d;
      pData_q   <= pData_d;
      valid_q   <= valid_d;
      parErr_q  <= parErr_d;
      stopErr_q <= stopErr_d;
      overrun_q <= overrun_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign p_data     = pData_q;
  assign data_valid = valid_q;
  assign par_error  = parErr_q;
  assign stop_error = stopErr_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: serial frames are driven onto rx_in, the expected
// frame is queued at stimulus time and a monitor checks each presented frame.
module tb_uart_rx_ctrl;

  localparam int P = 8;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         rx_in;
  logic         par_en;
  logic         par_typ;
  logic         data_ready;
  logic [W-1:0] p_data;
  logic         data_valid;
  logic         par_error;
  logic         stop_error;
  logic         overrun;
  logic         busy;

  typedef struct {
    logic [W-1:0] data;
    logic         parErr;
    logic         stopErr;
    int           riseCyc;
  } exp_t;

  exp_t expQ[$];
  exp_t mon;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic prevValid = 1'b0;

  uart_rx_ctrl #(
    .PRESCALE(P),
    .DATA_W  (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .par_en    (par_en),
    .par_typ   (par_typ),
    .data_ready(data_ready),
    .p_data    (p_data),
    .data_valid(data_valid),
    .par_error (par_error),
    .stop_error(stop_error),
    .overrun   (overrun),
    .busy      (busy)
  );

  // 10 ns clock with a running posedge count used for latency checks
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Inputs always change 1 ns after a rising edge
  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one serial frame; when the host will see it, the expected result is
  // queued from the frame contents: parity error is judged on the total count of
  // ones against the configured parity type, and presentation time follows from
  // where the start bit was first seen.
  task automatic applyStimulus(input logic [W-1:0] data, input logic pe, input logic typ,
                               input logic pb, input logic sb, input bit present,
                               input int gap, input bit toggleCfg);
    exp_t e;
    int   lowEdge;
    par_en  = pe;
    par_typ = typ;
    rx_in   = 1'b0;
    lowEdge = cyc + 1;
    if (present) begin
      e.data    = data;
      e.parErr  = pe && (((($countones(data) + int'(pb)) % 2) != int'(typ)));
      e.stopErr = !sb;
      e.riseCyc = lowEdge + (1 + W + int'(pe)) * P + P / 2 + 4;
      expQ.push_back(e);
    end
    waitCycles(P);
    for (int i = 0; i < W; i++) begin
      rx_in = data[i];
      if (i == 2 && toggleCfg) begin
        par_en  = 1'($urandom_range(0, 1));
        par_typ = 1'($urandom_range(0, 1));
      end
      waitCycles(P);
    end
    if (pe) begin
      rx_in = pb;
      waitCycles(P);
    end
    rx_in = sb;
    waitCycles(P);
    if (gap > 0) begin
      rx_in = 1'b1;
      waitCycles(gap);
    end
  endtask

  // Monitor: every newly presented frame is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (!rst) begin
      prevValid = 1'b0;
    end else begin
      if (data_valid && !prevValid) begin
        if (expQ.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpectedFrame: got p_data 0x%0h, expected no frame", p_data);
        end else begin
          mon = expQ.pop_front();
          checkOutput("p_data", 32'(p_data), 32'(mon.data));
          checkOutput("par_error", 32'(par_error), 32'(mon.parErr));
          checkOutput("stop_error", 32'(stop_error), 32'(mon.stopErr));
          checkOutput("validLatency", 32'(cyc), 32'(mon.riseCyc));
        end
      end
      prevValid = data_valid;
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int           busyCnt;
    int           validSeen;
    int           drainWait;
    logic [W-1:0] d;
    logic         pe;
    logic         typ;
    logic         pb;
    logic         sb;

    rst        = 1'b0;
    rx_in      = 1'b1;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    data_ready = 1'b1;
    waitCycles(3);
    checkOutput("rst p_data", 32'(p_data), 32'h0);
    checkOutput("rst data_valid", 32'(data_valid), 32'h0);
    checkOutput("rst par_error", 32'(par_error), 32'h0);
    checkOutput("rst stop_error", 32'(stop_error), 32'h0);
    checkOutput("rst overrun", 32'(overrun), 32'h0);
    checkOutput("rst busy", 32'(busy), 32'h0);
    rst = 1'b1;
    waitCycles(4);

    // Directed frames: plain, even parity good/bad, odd parity good
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6, 1'b0);
    applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6, 1'b1);
    applyStimulus(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6, 1'b1);
    applyStimulus(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6, 1'b0);

    // Stop bit low, then the line stays low: no new frame may start
    applyStimulus(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    waitCycles(40);
    checkOutput("busyLineHeldLow", 32'(busy), 32'h0);
    rx_in = 1'b1;
    waitCycles(4);

    // Short glitch on the idle line is a false start
    rx_in = 1'b0;
    waitCycles(2);
    rx_in     = 1'b1;
    busyCnt   = 0;
    validSeen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busyCnt++;
      if (data_valid) validSeen++;
    end
    waitCycles(1);
    checkOutput("glitchBusyCycles", 32'(busyCnt), 32'd6);
    checkOutput("glitchNoValid", 32'(validSeen), 32'd0);

    // Host stalled: second back-to-back frame is dropped and flagged
    data_ready = 1'b0;
    applyStimulus(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    applyStimulus(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b0);
    checkOutput("heldData", 32'(p_data), 32'h11);
    checkOutput("heldValid", 32'(data_valid), 32'h1);
    checkOutput("overrunSet", 32'(overrun), 32'h1);
    data_ready = 1'b1;
    waitCycles(1);
    data_ready = 1'b0;
    checkOutput("acceptClearsValid", 32'(data_valid), 32'h0);
    checkOutput("acceptClearsOverrun", 32'(overrun), 32'h0);

    // Hold a frame with both errors, then reset mid-way through data bit 4
    applyStimulus(8'hE7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4, 1'b0);
    d      = 8'hC3;
    par_en = 1'b0;
    rx_in  = 1'b0;
    waitCycles(P);
    for (int i = 0; i < 4; i++) begin
      rx_in = d[i];
      waitCycles(P);
    end
    rx_in = d[4];
    waitCycles(P / 2);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midRst p_data", 32'(p_data), 32'h0);
    checkOutput("midRst data_valid", 32'(data_valid), 32'h0);
    checkOutput("midRst par_error", 32'(par_error), 32'h0);
    checkOutput("midRst stop_error", 32'(stop_error), 32'h0);
    checkOutput("midRst overrun", 32'(overrun), 32'h0);
    checkOutput("midRst busy", 32'(busy), 32'h0);
    rx_in = 1'b1;
    @(posedge clk);
    #1;
    waitCycles(2);
    rst        = 1'b1;
    data_ready = 1'b1;
    waitCycles(4);
    applyStimulus(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6, 1'b0);

    // Random frames with random framing options and occasional errors
    for (int n = 0; n < 24; n++) begin
      d   = W'($urandom);
      pe  = 1'($urandom_range(0, 1));
      typ = 1'($urandom_range(0, 1));
      pb  = 1'($urandom_range(0, 1));
      sb  = ($urandom_range(0, 5) != 0);
      applyStimulus(d, pe, typ, pb, sb, 1'b1, int'($urandom_range(2, 12)), 1'b1);
    end

    drainWait = 0;
    while (expQ.size() != 0 && drainWait < 300) begin
      waitCycles(1);
      drainWait++;
    end
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
